// File: rtl/mem_issue_arbiter_pkg.sv
// rtl/mem_issue_arbiter_pkg.sv - shared types, encodings and widths for the memory issue arbiter
package mem_issue_arbiter_pkg;

    localparam int DATA_WIDTH_MEM_OP = 4;
    localparam int ROB_DEPTH         = 16;
    localparam int ROB_TAG_W         = $clog2(ROB_DEPTH);

    typedef logic [DATA_WIDTH_MEM_OP-1:0] mem_op_t;
    typedef logic [ROB_TAG_W-1:0]         rob_tag_t;

    localparam mem_op_t MEM_OP_LB = 4'd0;
    localparam mem_op_t MEM_OP_LH = 4'd1;
    localparam mem_op_t MEM_OP_LW = 4'd2;
    localparam mem_op_t MEM_OP_SB = 4'd5;
    localparam mem_op_t MEM_OP_SH = 4'd6;
    localparam mem_op_t MEM_OP_SW = 4'd7;

    typedef enum logic [1:0] {
        MEM_ARB_IDLE    = 2'd0,
        MEM_ARB_BUSY_LD = 2'd1,
        MEM_ARB_BUSY_ST = 2'd2
    } mem_arb_state_e;

    localparam int STB_OP_W   = DATA_WIDTH_MEM_OP;
    localparam int STB_ADDR_W = 32;
    localparam int STB_DATA_W = 32;

    typedef struct packed {
        logic [STB_OP_W-1:0]   op;
        logic [STB_ADDR_W-1:0] addr;
        logic [STB_DATA_W-1:0] data;
    } stb_entry_t;

    function automatic logic [29:0] word_addr(input logic [31:0] base, input logic [31:0] offs);
        return 30'((base + offs) >> 2);
    endfunction

endpackage

// File: rtl/mem_issue_arbiter_if.sv
// rtl/mem_issue_arbiter_if.sv - requester, mem_ctrl and writeback signals of the memory issue arbiter
interface mem_issue_arbiter_if import mem_issue_arbiter_pkg::*; ();

    logic        flush;
    logic        ld_req_valid;
    logic        ld_req_ready;
    mem_op_t     ld_req_op;
    logic [31:0] ld_req_imm;
    logic [31:0] ld_req_rs1;
    rob_tag_t    ld_req_Pdst;
    logic        st_commit_valid;
    logic        st_commit_ready;
    mem_op_t     st_commit_op;
    logic [31:0] st_commit_imm;
    logic [31:0] st_commit_rs1;
    logic [31:0] st_commit_rs2;
    logic        mem_ready;
    logic        load_data_valid;
    logic        store_finish;
    logic [31:0] load_data;
    logic        mem_issue_en;
    mem_op_t     mem_issue_queue_op;
    logic [31:0] mem_issue_queue_imm;
    logic [31:0] mem_issue_queue_rs1_value;
    logic [31:0] mem_issue_queue_rs2_value;
    rob_tag_t    mem_issue_queue_Pdst;
    logic        ld_wb_valid;
    logic [31:0] ld_wb_data;
    rob_tag_t    ld_wb_Pdst;
    logic        stb_empty;

    modport slave (
        input  flush, ld_req_valid, ld_req_op, ld_req_imm, ld_req_rs1, ld_req_Pdst,
        input  st_commit_valid, st_commit_op, st_commit_imm, st_commit_rs1, st_commit_rs2,
        input  mem_ready, load_data_valid, store_finish, load_data,
        output ld_req_ready, st_commit_ready, mem_issue_en, mem_issue_queue_op,
        output mem_issue_queue_imm, mem_issue_queue_rs1_value, mem_issue_queue_rs2_value,
        output mem_issue_queue_Pdst, ld_wb_valid, ld_wb_data, ld_wb_Pdst, stb_empty
    );

    modport master (
        output flush, ld_req_valid, ld_req_op, ld_req_imm, ld_req_rs1, ld_req_Pdst,
        output st_commit_valid, st_commit_op, st_commit_imm, st_commit_rs1, st_commit_rs2,
        output mem_ready, load_data_valid, store_finish, load_data,
        input  ld_req_ready, st_commit_ready, mem_issue_en, mem_issue_queue_op,
        input  mem_issue_queue_imm, mem_issue_queue_rs1_value, mem_issue_queue_rs2_value,
        input  mem_issue_queue_Pdst, ld_wb_valid, ld_wb_data, ld_wb_Pdst, stb_empty
    );

endinterface

// File: rtl/mem_store_buffer.sv
// rtl/mem_store_buffer.sv - in-order committed-store FIFO with a parallel word-address alias compare
module mem_store_buffer import mem_issue_arbiter_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_push,
    input  stb_entry_t  i_push_entry,
    input  logic        i_pop,
    output stb_entry_t  o_head,
    output logic        o_full,
    output logic        o_empty,
    input  logic [29:0] i_cmp_waddr,
    output logic        o_alias_hit
);

    localparam int PTR_W = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mem_store_buffer: DEPTH must be a power of two and at least 2");
    end

    stb_entry_t       r_mem [DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic [PTR_W:0]   w_count;
    logic [PTR_W-1:0] w_off;

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign o_head  = r_mem[r_rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_push_entry;
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        o_alias_hit = 1'b0;
        w_off       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off = PTR_W'(i) - r_rd_ptr[PTR_W-1:0];
            if (({1'b0, w_off} < w_count) && (r_mem[i].addr[31:2] == i_cmp_waddr))
                o_alias_hit = 1'b1;
        end
    end

endmodule

// File: rtl/mem_issue_arbiter.sv
// rtl/mem_issue_arbiter.sv - shares mem_ctrl between speculative loads and buffered stores
// Optional store age limit enabled by defining MEM_ARB_AGE_LIMIT_EN.
module mem_issue_arbiter import mem_issue_arbiter_pkg::*; #(
    parameter int STB_DEPTH    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input logic                 clk,
    input logic                 rst,
    mem_issue_arbiter_if.slave  bus
);

    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("mem_issue_arbiter: STARVE_LIMIT must be at least 1");
    end

    mem_arb_state_e r_state;
    logic           r_kill;
    rob_tag_t       r_tag;

    stb_entry_t  w_head;
    stb_entry_t  w_push_entry;
    logic        w_full;
    logic        w_empty;
    logic        w_alias;
    logic        w_push;
    logic [29:0] w_ld_waddr;
    logic        w_complete;
    logic        w_slot_open;
    logic        w_ld_elig;
    logic        w_age_force;
    logic        w_grant_st;
    logic        w_grant_ld;

    assign w_ld_waddr   = word_addr(bus.ld_req_rs1, bus.ld_req_imm);
    assign w_push_entry = '{op:   bus.st_commit_op,
                            addr: bus.st_commit_rs1 + bus.st_commit_imm,
                            data: bus.st_commit_rs2};
    assign w_push       = bus.st_commit_valid && !w_full;

    mem_store_buffer #(.DEPTH(STB_DEPTH)) u_stb (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_grant_st),
        .o_head       (w_head),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .i_cmp_waddr  (w_ld_waddr),
        .o_alias_hit  (w_alias)
    );

    assign w_complete  = ((r_state == MEM_ARB_BUSY_LD) && bus.load_data_valid) ||
                         ((r_state == MEM_ARB_BUSY_ST) && bus.store_finish);
    // Reset also closes the slot so no grant leaks out while rst is held.
    assign w_slot_open = !rst && bus.mem_ready && ((r_state == MEM_ARB_IDLE) || w_complete);
    assign w_ld_elig   = bus.ld_req_valid && !bus.flush && !w_alias;
    assign w_grant_st  = w_slot_open && !w_empty && (w_full || w_age_force || !w_ld_elig);
    assign w_grant_ld  = w_slot_open && w_ld_elig && !w_grant_st;

`ifdef MEM_ARB_AGE_LIMIT_EN
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

    logic [AGE_W-1:0] r_age_cnt;

    assign w_age_force = (r_age_cnt == AGE_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_age_cnt <= '0;
        else if (w_grant_st || w_empty)
            r_age_cnt <= '0;
        else if (w_grant_ld && (r_age_cnt != AGE_MAX))
            r_age_cnt <= r_age_cnt + 1'b1;
    end
`else
    assign w_age_force = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= MEM_ARB_IDLE;
            r_kill  <= 1'b0;
            r_tag   <= '0;
        end else begin
            if (w_grant_ld) begin
                r_state <= MEM_ARB_BUSY_LD;
                r_tag   <= bus.ld_req_Pdst;
            end else if (w_grant_st) begin
                r_state <= MEM_ARB_BUSY_ST;
            end else if (w_complete) begin
                r_state <= MEM_ARB_IDLE;
            end
            // kill only lives for the load currently in flight
            r_kill <= ((r_state == MEM_ARB_BUSY_LD) && !w_complete) ? (r_kill || bus.flush) : 1'b0;
        end
    end

    always_comb begin
        bus.mem_issue_en              = 1'b0;
        bus.mem_issue_queue_op        = '0;
        bus.mem_issue_queue_imm       = '0;
        bus.mem_issue_queue_rs1_value = '0;
        bus.mem_issue_queue_rs2_value = '0;
        bus.mem_issue_queue_Pdst      = '0;
        if (w_grant_ld) begin
            bus.mem_issue_en              = 1'b1;
            bus.mem_issue_queue_op        = bus.ld_req_op;
            bus.mem_issue_queue_imm       = bus.ld_req_imm;
            bus.mem_issue_queue_rs1_value = bus.ld_req_rs1;
            bus.mem_issue_queue_Pdst      = bus.ld_req_Pdst;
        end else if (w_grant_st) begin
            bus.mem_issue_en              = 1'b1;
            bus.mem_issue_queue_op        = w_head.op;
            bus.mem_issue_queue_rs1_value = w_head.addr;
            bus.mem_issue_queue_rs2_value = w_head.data;
        end
    end

    assign bus.ld_req_ready    = w_grant_ld;
    assign bus.st_commit_ready = !w_full;
    assign bus.stb_empty       = w_empty && (r_state != MEM_ARB_BUSY_ST);
    assign bus.ld_wb_valid     = bus.load_data_valid && (r_state == MEM_ARB_BUSY_LD) && !r_kill;
    assign bus.ld_wb_data      = bus.ld_wb_valid ? bus.load_data : 32'd0;
    assign bus.ld_wb_Pdst      = bus.ld_wb_valid ? r_tag : '0;

endmodule
